// File: rtl/letc_axi_sram_sub_if.sv
// AXI4 channel bundle between one letc_core manager and a word-wide subordinate.
// 4-bit IDs, 32-bit address/data; transfer size is fixed at 4 bytes, so AxSIZE is not carried.
interface axi_if;
  logic        awvalid;
  logic        awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;

  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport subordinate (
    input  awvalid, awid, awaddr, awlen, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );

  modport manager (
    output awvalid, awid, awaddr, awlen, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );
endinterface

// File: rtl/letc_axi_sram_sub.sv
// AXI4 subordinate wrapping a word-wide SRAM, one transaction in flight at a time.
// Define LETC_AXI_SRAM_SUB_ERR_EN to answer out-of-range beats with SLVERR instead of aliasing.
module letc_axi_sram_sub #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  axi_if.subordinate    axi
);
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {IDLE, WR_BURST, WR_RESP, RD_BURST} state_t;

  state_t      r_state;
  logic        r_prio_rd;
  logic        r_idle_rdy;
  logic [3:0]  r_id;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic        r_fixed;
  logic        r_err;
  logic        r_rd_more;
  logic        r_wready;
  logic        r_bvalid;
  logic [3:0]  r_bid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [3:0]  r_rid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_rlast;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_aw_pri, w_ar_pri, w_aw_hs, w_ar_hs;
  logic             w_w_hs, w_cnt_last, w_w_done, w_rd_issue, w_oor;
  logic [31:0]      w_off;
  logic [IDX_W-1:0] w_idx;

  // Tie-break: a request only loses its ready when the other class owns the tie.
  assign w_ar_pri    = axi.arvalid && (!axi.awvalid || r_prio_rd);
  assign w_aw_pri    = axi.awvalid && (!axi.arvalid || !r_prio_rd);
  assign axi.awready = r_idle_rdy && !w_ar_pri;
  assign axi.arready = r_idle_rdy && !w_aw_pri;
  assign w_aw_hs     = axi.awvalid && axi.awready;
  assign w_ar_hs     = axi.arvalid && axi.arready;

  assign w_off      = r_addr - BASE_ADDR;
  assign w_idx      = IDX_W'(w_off >> 2);
  assign w_w_hs     = (r_state == WR_BURST) && axi.wvalid && r_wready;
  assign w_cnt_last = (r_cnt == r_len);
  assign w_w_done   = w_w_hs && (axi.wlast || w_cnt_last);
  assign w_rd_issue = (r_state == RD_BURST) && r_rd_more && (!r_rvalid || axi.rready);

`ifdef LETC_AXI_SRAM_SUB_ERR_EN
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  assign w_oor = (w_off >= SPAN_BYTES);
`else
  assign w_oor = 1'b0;
`endif

  assign axi.wready = r_wready;
  assign axi.bvalid = r_bvalid;
  assign axi.bid    = r_bid;
  assign axi.bresp  = r_bresp;
  assign axi.rvalid = r_rvalid;
  assign axi.rid    = r_rid;
  assign axi.rdata  = r_rdata;
  assign axi.rresp  = r_rresp;
  assign axi.rlast  = r_rlast;

  // Byte-lane write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!rst && w_w_hs && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.wstrb[b]) r_mem[w_idx][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_prio_rd  <= 1'b0;
      r_idle_rdy <= 1'b0;
      r_id       <= 4'd0;
      r_addr     <= 32'd0;
      r_len      <= 8'd0;
      r_cnt      <= 8'd0;
      r_fixed    <= 1'b0;
      r_err      <= 1'b0;
      r_rd_more  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bid      <= 4'd0;
      r_bresp    <= RESP_OKAY;
      r_rvalid   <= 1'b0;
      r_rid      <= 4'd0;
      r_rdata    <= 32'd0;
      r_rresp    <= RESP_OKAY;
      r_rlast    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_idle_rdy <= 1'b1;
          r_cnt      <= 8'd0;
          r_err      <= 1'b0;
          if (w_aw_hs) begin
            r_id       <= axi.awid;
            r_addr     <= axi.awaddr;
            r_len      <= axi.awlen;
            r_fixed    <= (axi.awburst == BURST_FIXED);
            r_prio_rd  <= 1'b1;
            r_idle_rdy <= 1'b0;
            r_wready   <= 1'b1;
            r_state    <= WR_BURST;
          end else if (w_ar_hs) begin
            r_id       <= axi.arid;
            r_addr     <= axi.araddr;
            r_len      <= axi.arlen;
            r_fixed    <= (axi.arburst == BURST_FIXED);
            r_prio_rd  <= 1'b0;
            r_idle_rdy <= 1'b0;
            r_rd_more  <= 1'b1;
            r_state    <= RD_BURST;
          end
        end
        WR_BURST: begin
          if (w_w_hs) begin
            if (!r_fixed) r_addr <= r_addr + 32'd4;
            r_cnt <= r_cnt + 8'd1;
            if (w_w_done) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= (r_err || w_oor || (axi.wlast != w_cnt_last)) ? RESP_SLVERR : RESP_OKAY;
              r_state  <= WR_RESP;
            end else if (w_oor) begin
              r_err <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (axi.bready) begin
            r_bvalid   <= 1'b0;
            r_idle_rdy <= 1'b1;
            r_state    <= IDLE;
          end
        end
        RD_BURST: begin
          // The output register doubles as the RAM read register, so a stall simply holds it.
          if (w_rd_issue) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_oor ? 32'd0 : r_mem[w_idx];
            r_rresp  <= w_oor ? RESP_SLVERR : RESP_OKAY;
            r_rid    <= r_id;
            r_rlast  <= w_cnt_last;
            r_cnt    <= r_cnt + 8'd1;
            if (!r_fixed) r_addr <= r_addr + 32'd4;
            if (w_cnt_last) r_rd_more <= 1'b0;
          end else if (axi.rready) begin
            r_rvalid <= 1'b0;
          end
          if (r_rvalid && axi.rready && r_rlast) begin
            r_idle_rdy <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_letc_axi_sram_sub.sv
// Directed bench for letc_axi_sram_sub: reset, tie-break, strobes, bursts, backpressure,
// WLAST mismatch, out-of-range handling and mid-burst reset.
module tb_letc_axi_sram_sub;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   beat;
  int   cyc;
  logic        have_held;
  logic [31:0] held_data;
  logic        held_last;

  axi_if axi ();

  letc_axi_sram_sub #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .axi (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic [3:0] id);
    int n;
    axi.awvalid = 1'b1; axi.awaddr = a; axi.awlen = l; axi.awburst = b; axi.awid = id;
    #1;
    n = 0;
    while (!axi.awready && n < 40) begin tick(); n++; end
    chk("aw_ready", 32'(axi.awready), 32'd1);
    tick();
    axi.awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic [3:0] id);
    int n;
    axi.arvalid = 1'b1; axi.araddr = a; axi.arlen = l; axi.arburst = b; axi.arid = id;
    #1;
    n = 0;
    while (!axi.arready && n < 40) begin tick(); n++; end
    chk("ar_ready", 32'(axi.arready), 32'd1);
    tick();
    axi.arvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic last);
    int n;
    axi.wvalid = 1'b1; axi.wdata = d; axi.wstrb = s; axi.wlast = last;
    #1;
    n = 0;
    while (!axi.wready && n < 40) begin tick(); n++; end
    chk("w_ready", 32'(axi.wready), 32'd1);
    tick();
    axi.wvalid = 1'b0;
  endtask

  task automatic b_recv(input string tag, input logic [1:0] resp, input logic [3:0] id);
    int n;
    axi.bready = 1'b1;
    #1;
    n = 0;
    while (!axi.bvalid && n < 40) begin tick(); n++; end
    chk({tag, "_bvalid"}, 32'(axi.bvalid), 32'd1);
    chk({tag, "_bresp"}, 32'(axi.bresp), 32'(resp));
    chk({tag, "_bid"}, 32'(axi.bid), 32'(id));
    tick();
    axi.bready = 1'b0;
  endtask

  task automatic r_recv(input string tag, input logic [31:0] d, input logic [1:0] resp,
                        input logic last, input logic [3:0] id);
    int n;
    axi.rready = 1'b1;
    #1;
    n = 0;
    while (!axi.rvalid && n < 40) begin tick(); n++; end
    chk({tag, "_rvalid"}, 32'(axi.rvalid), 32'd1);
    chk({tag, "_rdata"}, axi.rdata, d);
    chk({tag, "_rresp"}, 32'(axi.rresp), 32'(resp));
    chk({tag, "_rlast"}, 32'(axi.rlast), 32'(last));
    chk({tag, "_rid"}, 32'(axi.rid), 32'(id));
    tick();
    axi.rready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    axi.awvalid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awburst = INCR; axi.awid = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
    axi.arvalid = 0; axi.araddr = 0; axi.arlen = 0; axi.arburst = INCR; axi.arid = 0;
    axi.rready = 0;
    repeat (3) tick();

    // Reset state
    chk("rst_awready", 32'(axi.awready), 32'd0);
    chk("rst_arready", 32'(axi.arready), 32'd0);
    chk("rst_wready", 32'(axi.wready), 32'd0);
    chk("rst_bvalid", 32'(axi.bvalid), 32'd0);
    chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
    chk("rst_bresp", 32'(axi.bresp), 32'd0);
    chk("rst_rresp", 32'(axi.rresp), 32'd0);
    chk("rst_bid", 32'(axi.bid), 32'd0);
    chk("rst_rid", 32'(axi.rid), 32'd0);
    chk("rst_rdata", axi.rdata, 32'd0);

    // Ready rises only in the second cycle after reset release
    rst = 1'b0;
    #1;
    chk("post_rst_cyc1_awready", 32'(axi.awready), 32'd0);
    chk("post_rst_cyc1_arready", 32'(axi.arready), 32'd0);
    tick();
    chk("post_rst_cyc2_awready", 32'(axi.awready), 32'd1);
    chk("post_rst_cyc2_arready", 32'(axi.arready), 32'd1);

    // First tie after reset: write wins
    axi.awvalid = 1'b1; axi.awaddr = 32'h10; axi.awlen = 8'd0; axi.awburst = INCR; axi.awid = 4'd1;
    axi.arvalid = 1'b1; axi.araddr = 32'h10; axi.arlen = 8'd0; axi.arburst = INCR; axi.arid = 4'd9;
    #1;
    chk("tie1_awready", 32'(axi.awready), 32'd1);
    chk("tie1_arready", 32'(axi.arready), 32'd0);
    tick();
    axi.awvalid = 1'b0; axi.arvalid = 1'b0;
    w_send(32'hDEADBEEF, 4'hF, 1'b1);
    b_recv("single_wr", OKAY, 4'd1);

    // Second tie: read wins; first RVALID exactly two cycles after AR handshake
    axi.awvalid = 1'b1; axi.awaddr = 32'h20; axi.awlen = 8'd0; axi.awburst = INCR; axi.awid = 4'd2;
    axi.arvalid = 1'b1; axi.araddr = 32'h10; axi.arlen = 8'd0; axi.arburst = INCR; axi.arid = 4'd9;
    #1;
    chk("tie2_awready", 32'(axi.awready), 32'd0);
    chk("tie2_arready", 32'(axi.arready), 32'd1);
    tick();
    axi.arvalid = 1'b0;
    chk("rd_lat_cyc1_rvalid", 32'(axi.rvalid), 32'd0);
    tick();
    chk("rd_lat_cyc2_rvalid", 32'(axi.rvalid), 32'd1);
    r_recv("single_rd", 32'hDEADBEEF, OKAY, 1'b1, 4'd9);

    // Byte strobes: pending write to 0x20 is accepted now
    aw_send(32'h20, 8'd0, INCR, 4'd2);
    w_send(32'h11223344, 4'hF, 1'b1);
    b_recv("strb_wr1", OKAY, 4'd2);
    aw_send(32'h20, 8'd0, INCR, 4'd3);
    w_send(32'hAABBCCDD, 4'h5, 1'b1);
    b_recv("strb_wr2", OKAY, 4'd3);
    ar_send(32'h20, 8'd0, INCR, 4'd4);
    r_recv("strb_rd", 32'h11BB33DD, OKAY, 1'b1, 4'd4);

    // INCR write burst of 1..4 at 0x40, then read back under RREADY backpressure
    aw_send(32'h40, 8'd3, INCR, 4'd5);
    w_send(32'd1, 4'hF, 1'b0);
    w_send(32'd2, 4'hF, 1'b0);
    w_send(32'd3, 4'hF, 1'b0);
    w_send(32'd4, 4'hF, 1'b1);
    b_recv("burst_wr", OKAY, 4'd5);
    ar_send(32'h40, 8'd3, INCR, 4'd6);
    beat = 0; cyc = 0; have_held = 1'b0; held_data = 32'd0; held_last = 1'b0;
    while (beat < 4 && cyc < 60) begin
      axi.rready = (cyc % 3 == 0);
      #1;
      if (have_held) begin
        chk("bp_stall_rvalid", 32'(axi.rvalid), 32'd1);
        chk("bp_stall_rdata", axi.rdata, held_data);
        chk("bp_stall_rlast", 32'(axi.rlast), 32'(held_last));
        have_held = 1'b0;
      end
      if (axi.rvalid) begin
        if (axi.rready) begin
          chk("bp_rdata", axi.rdata, 32'(beat + 1));
          chk("bp_rlast", 32'(axi.rlast), 32'(beat == 3));
          beat++;
        end else begin
          have_held = 1'b1;
          held_data = axi.rdata;
          held_last = axi.rlast;
        end
      end
      tick();
      cyc++;
    end
    axi.rready = 1'b0;
    chk("bp_beats", 32'(beat), 32'd4);
    chk("bp_done_rvalid", 32'(axi.rvalid), 32'd0);

    // FIXED burst keeps the address: second beat overwrites the first
    aw_send(32'h80, 8'd1, FIXED, 4'd7);
    w_send(32'h55, 4'hF, 1'b0);
    w_send(32'h66, 4'hF, 1'b1);
    b_recv("fixed_wr", OKAY, 4'd7);
    ar_send(32'h80, 8'd0, INCR, 4'd7);
    r_recv("fixed_rd", 32'h66, OKAY, 1'b1, 4'd7);

    // Early WLAST on a two-beat burst
    aw_send(32'h90, 8'd1, INCR, 4'd8);
    w_send(32'h77, 4'hF, 1'b1);
    b_recv("wlast_mismatch", SLVERR, 4'd8);

    // Out-of-range read: word 64 of a 64-word SRAM
    aw_send(32'h0, 8'd0, INCR, 4'd1);
    w_send(32'hCAFEF00D, 4'hF, 1'b1);
    b_recv("word0_wr", OKAY, 4'd1);
    ar_send(32'h100, 8'd0, INCR, 4'd2);
`ifdef LETC_AXI_SRAM_SUB_ERR_EN
    r_recv("oor_rd", 32'd0, SLVERR, 1'b1, 4'd2);
`else
    r_recv("oor_rd", 32'hCAFEF00D, OKAY, 1'b1, 4'd2);
`endif

    // Reset pulsed during the second beat of an 8-beat read
    ar_send(32'h0, 8'd7, INCR, 4'd3);
    r_recv("mid_rst_beat1", 32'hCAFEF00D, OKAY, 1'b0, 4'd3);
    axi.rready = 1'b1;
    #1;
    chk("mid_rst_beat2_rvalid", 32'(axi.rvalid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rvalid_next", 32'(axi.rvalid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_rvalid_hold", 32'(axi.rvalid), 32'd0);
    end
    axi.rready = 1'b0;
    ar_send(32'h10, 8'd0, INCR, 4'd5);
    r_recv("post_rst_rd", 32'hDEADBEEF, OKAY, 1'b1, 4'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
